// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: FIFO-buffered Philips I2S transmitter.
// Each sample is mirrored on both slots; bclk/lrclk are derived from clk.
module i2s_sample_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_DIV   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  enable,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sd,
    output logic                  fifo_full,
    output logic [FIFO_AW:0]      fifo_level,
    output logic                  overflow,
    output logic                  underrun
);
    localparam int BW = $clog2(2 * DATA_WIDTH);
    localparam int SW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * DATA_WIDTH - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(DATA_WIDTH);
    localparam logic [SW-1:0] MSB_IDX  = SW'(DATA_WIDTH - 1);
    localparam logic [FIFO_AW:0] LVL_MAX = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [FIFO_AW:0]      count;
    logic [CW-1:0]         div_cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] frame_word;

    logic          div_tc;
    logic          fall;
    logic          load;
    logic          wr;
    logic          pop;
    logic [BW-1:0] bit_nxt;
    logic [BW-1:0] slot_pos;
    logic [SW-1:0] sd_sel;
    logic          sd_nxt;
    logic          lr_nxt;

    assign fifo_full  = (count == LVL_MAX);
    assign fifo_level = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // First falling edge out of IDLE acts as a frame load at the last bit.
    always_comb begin
        state_nxt = state;
        if (!enable)   state_nxt = IDLE;
        else if (fall) state_nxt = RUN;
    end

    always_comb begin
        div_tc  = enable && (div_cnt == DIV_LAST);
        fall    = div_tc && i2s_bclk;
        bit_nxt = BIT_LAST;
        if (state == RUN) begin
            bit_nxt = (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
        end
        load     = fall && (bit_nxt == BIT_LAST);
        wr       = data_valid && !fifo_full;
        pop      = load && (count != '0);
        slot_pos = (bit_nxt >= SLOT_LEN) ? bit_nxt - SLOT_LEN : bit_nxt;
        sd_sel   = MSB_IDX - SW'(slot_pos);
        sd_nxt   = frame_word[sd_sel];
        lr_nxt   = (bit_nxt != BIT_LAST)
                && (bit_nxt >= SLOT_LEN - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overflow <= data_valid && fifo_full;
            underrun <= load && (count == '0);
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // On a load edge sd still shifts out the old word's last bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            i2s_bclk   <= 1'b0;
            i2s_lrclk  <= 1'b0;
            i2s_sd     <= 1'b0;
            bit_idx    <= '0;
            frame_word <= '0;
        end else if (!enable) begin
            div_cnt    <= '0;
            i2s_bclk   <= 1'b0;
            i2s_lrclk  <= 1'b0;
            i2s_sd     <= 1'b0;
            bit_idx    <= '0;
            frame_word <= '0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) i2s_bclk <= ~i2s_bclk;
            if (fall) begin
                bit_idx   <= bit_nxt;
                i2s_sd    <= sd_nxt;
                i2s_lrclk <= lr_nxt;
            end
            if (load) frame_word <= pop ? mem[rd_ptr] : '0;
        end
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Self-checking bench for i2s_sample_tx: FIFO model plus serial
// decoder compared against a queue of expected frames.
module tb_i2s_sample_tx;
    localparam int W = 16;
    localparam int FRAME = 128;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         enable;
    logic         i2s_bclk;
    logic         i2s_lrclk;
    logic         i2s_sd;
    logic         fifo_full;
    logic [2:0]   fifo_level;
    logic         overflow;
    logic         underrun;

    always #5 clk = ~clk;

    i2s_sample_tx #(
        .DATA_WIDTH(W),
        .BCLK_DIV(2),
        .FIFO_DEPTH(4),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .data_valid(data_valid),
        .enable(enable),
        .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk),
        .i2s_sd(i2s_sd),
        .fifo_full(fifo_full),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .underrun(underrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference model: FIFO contents and frames loaded for transmission.
    logic [W-1:0] m_q[$];
    logic [W-1:0] exp_frames[$];
    int           en_cyc = 0;
    bit           m_ovf = 0;
    bit           m_und = 0;
    bit           m_idle = 1;
    bit           m_full;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            exp_frames.delete();
            en_cyc = 0;
            m_ovf  = 0;
            m_und  = 0;
            m_idle = 1;
        end else begin
            m_full = (m_q.size() == 4);
            m_ovf  = data_valid && m_full;
            m_und  = 0;
            if (enable) begin
                en_cyc++;
                m_idle = 0;
                if (en_cyc >= 4 && (en_cyc - 4) % FRAME == 0) begin
                    if (m_q.size() > 0) begin
                        exp_frames.push_back(m_q.pop_front());
                    end else begin
                        exp_frames.push_back('0);
                        m_und = 1;
                    end
                end
            end else begin
                en_cyc = 0;
                m_idle = 1;
                exp_frames.delete();
            end
            if (data_valid && !m_full) m_q.push_back(data_in);
        end
    end

    // Serial decoder: a slot starts on the bit after lrclk changes.
    bit           prev_bclk = 0;
    bit           prev_lr = 1;
    bit           skip = 1;
    bit           armed = 0;
    bit           have_left = 0;
    bit           slot = 0;
    int           nbits = 0;
    int           nframes = 0;
    logic [W-1:0] word = '0;
    logic [W-1:0] left_word = '0;
    logic [W-1:0] exp_w;

    always @(negedge clk) begin
        chk("level", 32'(fifo_level), 32'(m_q.size()));
        chk("full", fifo_full, m_q.size() == 4);
        chk("ovf", overflow, m_ovf);
        chk("und", underrun, m_und);
        if (m_idle) begin
            chk("idle_bclk", i2s_bclk, 0);
            chk("idle_lr", i2s_lrclk, 0);
            chk("idle_sd", i2s_sd, 0);
        end
        if (reset || !enable) begin
            prev_bclk = 0;
            prev_lr   = 1;
            skip      = 1;
            armed     = 0;
            have_left = 0;
        end else begin
            if (i2s_bclk && !prev_bclk) begin
                if (skip) begin
                    skip = 0;
                end else begin
                    if (armed) begin
                        word = {word[W-2:0], i2s_sd};
                        nbits++;
                        if (nbits == W) begin
                            armed = 0;
                            if (!slot) begin
                                left_word = word;
                                have_left = 1;
                            end else begin
                                chk("left_seen", have_left, 1);
                                chk("sb_depth", exp_frames.size() > 0, 1);
                                if (exp_frames.size() > 0) begin
                                    exp_w = exp_frames.pop_front();
                                    chk("left_word", left_word, exp_w);
                                    chk("right_word", word, exp_w);
                                    nframes++;
                                end
                                have_left = 0;
                            end
                        end
                    end
                    if (i2s_lrclk != prev_lr) begin
                        if (armed) chk("slot_len", nbits, W);
                        armed = 1;
                        nbits = 0;
                        word  = '0;
                        slot  = i2s_lrclk;
                    end
                    prev_lr = i2s_lrclk;
                end
            end
            prev_bclk = i2s_bclk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [W-1:0] v);
        data_valid = 1'b1;
        data_in    = v;
        tick();
        data_valid = 1'b0;
    endtask

    int  cnt;
    int  mx;
    int  su;
    int  so;
    bit  seen;

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_lr", i2s_lrclk, 0);
        chk("rst_sd", i2s_sd, 0);
        chk("rst_lvl", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_und", underrun, 0);

        // single frame, then free-running underrun frames
        write(16'hA5C3);
        enable = 1'b1;
        repeat (4 + FRAME + 40) tick();
        cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (underrun) cnt++;
        end
        chk("und_per_256", cnt, 2);

        // overflow with serializer idle
        enable = 1'b0;
        tick();
        write(16'h1111);
        write(16'h2222);
        write(16'h3333);
        chk("full3", fifo_full, 0);
        write(16'h4444);
        chk("full4", fifo_full, 1);
        chk("lvl4", fifo_level, 4);
        data_valid = 1'b1;
        data_in    = 16'h5555;
        tick();
        data_valid = 1'b0;
        chk("ovf_pulse", overflow, 1);
        tick();
        chk("ovf_clear", overflow, 0);
        chk("ovf_lvl", fifo_level, 4);
        enable = 1'b1;
        repeat (4 * FRAME + 150) tick();

        // reset mid-frame at bit 7 with three entries queued
        enable = 1'b0;
        tick();
        write(16'hC3A5);
        write(16'h5A5A);
        write(16'h1234);
        write(16'hBEEF);
        enable = 1'b1;
        repeat (38) tick();
        chk("pre_rst_lvl", fifo_level, 3);
        chk("pre_rst_bclk", i2s_bclk, 1);
        chk("pre_rst_sd", i2s_sd, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_bclk", i2s_bclk, 0);
        chk("mid_rst_lr", i2s_lrclk, 0);
        chk("mid_rst_sd", i2s_sd, 0);
        chk("mid_rst_lvl", fifo_level, 0);
        chk("mid_rst_full", fifo_full, 0);
        tick();
        tick();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            if (underrun) seen = 1;
        end
        chk("rst_first_und", seen, 1);
        repeat (200) tick();

        // streaming at exactly the frame rate
        enable = 1'b0;
        tick();
        write(16'h0001);
        enable = 1'b1;
        mx = 0;
        su = 0;
        so = 0;
        for (int k = 1; k <= 480; k++) begin
            if (k == 11) begin
                data_valid = 1'b1;
                data_in    = 16'h8000;
            end
            if (k == 11 + FRAME) begin
                data_valid = 1'b1;
                data_in    = 16'h7FFF;
            end
            if (k == 11 + 2 * FRAME) begin
                data_valid = 1'b1;
                data_in    = 16'hFFFF;
            end
            tick();
            data_valid = 1'b0;
            if (int'(fifo_level) > mx) mx = int'(fifo_level);
            if (underrun) su++;
            if (overflow) so++;
        end
        chk("stream_max_lvl", mx, 1);
        chk("stream_und", su, 0);
        chk("stream_ovf", so, 0);
        repeat (150) tick();

        // write on the boundary cycle, then drop enable mid-slot
        enable = 1'b0;
        tick();
        write(16'h1357);
        enable = 1'b1;
        for (int k = 1; k <= 299; k++) begin
            if (k == 20) begin
                data_valid = 1'b1;
                data_in    = 16'h2468;
            end
            if (k == 4 + FRAME) begin
                data_valid = 1'b1;
                data_in    = 16'hACE1;
            end
            if (k == 280) begin
                data_valid = 1'b1;
                data_in    = 16'hFACE;
            end
            tick();
            data_valid = 1'b0;
            if (k == 4 + FRAME) begin
                chk("simul_lvl", fifo_level, 1);
                chk("simul_und", underrun, 0);
            end
        end
        chk("pre_drop_bclk", i2s_bclk, 1);
        chk("pre_drop_sd", i2s_sd, 1);
        enable = 1'b0;
        tick();
        chk("drop_bclk", i2s_bclk, 0);
        chk("drop_lr", i2s_lrclk, 0);
        chk("drop_sd", i2s_sd, 0);
        chk("drop_lvl", fifo_level, 1);
        enable = 1'b1;
        repeat (4 + FRAME + 60) tick();
        enable = 1'b0;
        repeat (2) tick();
        chk("frames_seen", nframes >= 12, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_sample_tx.md
Name: i2s_sample_tx

Overview:
- Transmit-side counterpart of the mean-removal receive path.
- Accepts parallel audio samples with a one-cycle valid strobe, buffers them in a small FIFO, and serializes each sample as a Philips-format I2S frame.
- Generates its own bit clock and word-select clock from clk. Each sample is mirrored on the left and right slots.
- Drives the codec/DAC or loop-back port at the output end of the i2s_iot datapath.

Parameters:
DATA_WIDTH, 16, sample width and slot width in bits
BCLK_DIV, 2, clk cycles per bclk half-period (>=1)
FIFO_DEPTH, 4, sample buffer entries (power of two)
FIFO_AW, 2, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
data_in  input  DATA_WIDTH  sample to transmit, two's complement
data_valid  input  1  one-cycle strobe, qualifies data_in
enable  input  1  1 = run serializer; 0 = idle (FIFO still accepts writes)
i2s_bclk  output  1  bit clock
i2s_lrclk  output  1  word select, 0 = left slot, 1 = right slot
i2s_sd  output  1  serial data, MSB first
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_level  output  FIFO_AW+1  current entry count
overflow  output  1  one-cycle pulse: write dropped
underrun  output  1  one-cycle pulse: frame started with FIFO empty

Behaviour:
- Reset: i2s_bclk, i2s_lrclk, i2s_sd, overflow and underrun = 0; FIFO empty (level 0, fifo_full 0); all counters 0. Reset mid-frame aborts the frame immediately and discards buffered samples.
- FIFO write: a write occurs when data_valid=1 and fifo_full=0.
  - data_valid=1 with fifo_full=1 drops the sample and pulses overflow for that cycle.
  - fifo_full comes from the registered count, so a write is dropped while full even if a pop happens in the same cycle.
- Write and pop in the same cycle with the FIFO non-empty and not full: level is unchanged and order is preserved.
- Pop on an empty FIFO while a write occurs in the same cycle: the pop sees empty; the write is stored.
- Clock divider: counter runs 0..BCLK_DIV-1 while enable=1. i2s_bclk toggles at terminal count, giving a bclk period of 2*BCLK_DIV clk cycles.
- All output changes (i2s_sd, i2s_lrclk) are registered and occur in the same clk cycle that i2s_bclk goes 1->0.
- Bit index b runs 0..2*DATA_WIDTH-1 and advances on each bclk falling edge.
  - i2s_sd = frame_word[DATA_WIDTH-1-(b mod DATA_WIDTH)].
  - i2s_lrclk = 1 when (b+1) mod 2*DATA_WIDTH >= DATA_WIDTH. This gives the Philips one-bit delay: lrclk changes one bclk before each slot MSB.
- Frame boundary is the falling edge on which b wraps from 2*DATA_WIDTH-1 to 0.
  - The boundary cycle pops the FIFO head into frame_word.
  - If the FIFO is empty, frame_word = 0 and underrun pulses for one clk cycle.
- Enable rise: from idle, the divider starts and the first bclk falling edge is treated as a frame boundary with b=2*DATA_WIDTH-1 (load, lrclk=0). The MSB is driven on the next falling edge.
- Enable fall: takes effect immediately. bclk, lrclk, sd and all counters go to 0. The in-progress frame_word is discarded; FIFO contents are kept.
- Latency: a sample written before a boundary is on i2s_sd (MSB) one bclk period after that boundary.
- Throughput: one sample per 2*DATA_WIDTH*2*BCLK_DIV clk cycles (128 at defaults). A faster upstream overflows; a slower one underruns.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset mid-frame at b=7 with 3 entries queued -> same cycle all outputs 0, fifo_level 0; after release with enable=1 the first frame shows underrun=1.
- Single frame: write 0xA5C3, raise enable -> one boundary pop, lrclk low 16 bclk then high 16 bclk (each change one bclk before the MSB), i2s_sd = 1010010111000011 on both slots, sampled on bclk rising.
- Underrun: enable=1, no writes -> i2s_sd constant 0, underrun pulses exactly once every 128 clk cycles, lrclk still toggles every 64 clk cycles.
- Overflow: enable=0, write 5 samples back-to-back -> fifo_full=1 after 4th, 5th dropped with overflow=1 for one cycle, fifo_level=4; enabling then transmits samples 1-4 in order.
- Streaming: write 0x0001, 0x8000, 0x7FFF, 0xFFFF, one every 128 clk cycles, enable held -> frames carry the samples in order, no underrun, no overflow, fifo_level never exceeds 1.
- Simultaneous events: write on the exact boundary cycle with 1 entry queued -> head popped, new sample stored, fifo_level stays 1; enable dropped mid-slot -> bclk/lrclk/sd 0 next cycle, queued entries retained.
